// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execution sequencer: opcodes, FSM state type,
// datapath width and the carry-in rule for subtract-style operations.
package alu_exec_pkg;

  localparam int W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } state_t;

  // Compare ops are evaluated by the ALU as x + ~y + 1, same as subtract.
  function automatic logic needs_cin(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_LT) || (op == OP_EQ);
  endfunction

endpackage

// File: rtl/alu_exec_regfile.sv
// Architectural register file: one synchronous write port, two combinational
// operand read ports and one combinational debug read port.
module alu_exec_regfile #(
  parameter int NREG = 4,
  parameter int RAW  = 2,
  parameter int W    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_we,
  input  logic [RAW-1:0] i_waddr,
  input  logic [W-1:0]   i_wdata,
  input  logic [RAW-1:0] i_raddr1,
  output logic [W-1:0]   o_rdata1,
  input  logic [RAW-1:0] i_raddr2,
  output logic [W-1:0]   o_rdata2,
  input  logic [RAW-1:0] i_dbg_addr,
  output logic [W-1:0]   o_dbg_data
);

  logic [W-1:0] r_mem [NREG];

  // Storage array, cleared on reset, written by the writeback stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= {W{1'b0}};
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1   = r_mem[i_raddr1];
  assign o_rdata2   = r_mem[i_raddr2];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_exec_seq.sv
// Execution sequencer in front of the 4-bit combinational ALU (IDLE -> EXEC -> WB).
// Build option ALU_EXEC_SEQ_BYPASS_EN: accept in WB and forward the result being written.
module alu_exec_seq
  import alu_exec_pkg::*;
#(
  parameter int NREG = 4,
  parameter int RAW  = 2,
  parameter int W    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_op,
  input  logic [RAW-1:0] cmd_rd,
  input  logic [RAW-1:0] cmd_rs1,
  input  logic [RAW-1:0] cmd_rs2,
  input  logic           cmd_imm_en,
  input  logic [W-1:0]   cmd_imm,
  output logic [2:0]     alu_op,
  output logic           alu_in_c,
  output logic [W-1:0]   alu_in_x,
  output logic [W-1:0]   alu_in_y,
  input  logic [W-1:0]   alu_out_s,
  input  logic           alu_out_c,
  input  logic           alu_zero,
  input  logic           alu_overflow,
  output logic           res_valid,
  output logic [W-1:0]   res_data,
  output logic           flag_c,
  output logic           flag_z,
  output logic           flag_v,
  input  logic [RAW-1:0] dbg_addr,
  output logic [W-1:0]   dbg_data
);

  if ((W != 4) || (NREG < 2) || (RAW != $clog2(NREG)) || ((1 << RAW) != NREG)) begin : g_bad_cfg
    $error("alu_exec_seq: W must be 4 and NREG a power of two equal to 2**RAW");
  end

  state_t         r_state;
  logic [2:0]     r_op;
  logic           r_cin;
  logic [W-1:0]   r_x;
  logic [W-1:0]   r_y;
  logic [RAW-1:0] r_rd;
  logic [W-1:0]   r_res;
  logic           r_flag_c;
  logic           r_flag_z;
  logic           r_flag_v;
  logic           r_res_valid;

  logic           w_ready;
  logic           w_accept;
  logic           w_we;
  logic           w_fwd1;
  logic           w_fwd2;
  logic [W-1:0]   w_rdata1;
  logic [W-1:0]   w_rdata2;
  logic [W-1:0]   w_x;
  logic [W-1:0]   w_y;

  assign w_we = (r_state == WB);

`ifdef ALU_EXEC_SEQ_BYPASS_EN
  // A command accepted in WB must see the value being written back this cycle.
  assign w_ready = (r_state == IDLE) || (r_state == WB);
  assign w_fwd1  = w_we && (cmd_rs1 == r_rd);
  assign w_fwd2  = w_we && !cmd_imm_en && (cmd_rs2 == r_rd);
`else
  assign w_ready = (r_state == IDLE);
  assign w_fwd1  = 1'b0;
  assign w_fwd2  = 1'b0;
`endif

  assign w_accept = cmd_valid && w_ready;

  alu_exec_regfile #(
    .NREG (NREG),
    .RAW  (RAW),
    .W    (W)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_we),
    .i_waddr    (r_rd),
    .i_wdata    (r_res),
    .i_raddr1   (cmd_rs1),
    .o_rdata1   (w_rdata1),
    .i_raddr2   (cmd_rs2),
    .o_rdata2   (w_rdata2),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  always_comb begin
    w_x = w_rdata1;
    w_y = w_rdata2;
    if (w_fwd1) begin
      w_x = r_res;
    end else begin
      w_x = w_rdata1;
    end
    if (cmd_imm_en) begin
      w_y = cmd_imm;
    end else if (w_fwd2) begin
      w_y = r_res;
    end else begin
      w_y = w_rdata2;
    end
  end

  // Sequencer: operand latches double as the ALU drive, cleared once EXEC ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= 3'b000;
      r_cin       <= 1'b0;
      r_x         <= {W{1'b0}};
      r_y         <= {W{1'b0}};
      r_rd        <= {RAW{1'b0}};
      r_res       <= {W{1'b0}};
      r_flag_c    <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_v    <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        EXEC: begin
          r_res       <= alu_out_s;
          r_flag_c    <= alu_out_c;
          r_flag_z    <= alu_zero;
          r_flag_v    <= alu_overflow;
          r_res_valid <= 1'b1;
          r_op        <= 3'b000;
          r_cin       <= 1'b0;
          r_x         <= {W{1'b0}};
          r_y         <= {W{1'b0}};
          r_state     <= WB;
        end
        IDLE, WB: begin
          if (w_accept) begin
            r_op    <= cmd_op;
            r_cin   <= needs_cin(cmd_op);
            r_x     <= w_x;
            r_y     <= w_y;
            r_rd    <= cmd_rd;
            r_state <= EXEC;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = w_ready;
  assign alu_op    = r_op;
  assign alu_in_c  = r_cin;
  assign alu_in_x  = r_x;
  assign alu_in_y  = r_y;
  assign res_valid = r_res_valid;
  assign res_data  = r_res;
  assign flag_c    = r_flag_c;
  assign flag_z    = r_flag_z;
  assign flag_v    = r_flag_v;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: behavioural ALU on the alu_* ports and an
// arithmetic reference model of the register file, flags and handshake timing.
module tb_alu_exec_seq;

  localparam int NREG = 4;
  localparam int RAW  = 2;
  localparam int W    = 4;

  localparam logic [2:0] T_ADD = 3'd0;
  localparam logic [2:0] T_SUB = 3'd1;
  localparam logic [2:0] T_NOT = 3'd2;
  localparam logic [2:0] T_AND = 3'd3;
  localparam logic [2:0] T_OR  = 3'd4;
  localparam logic [2:0] T_XOR = 3'd5;
  localparam logic [2:0] T_LT  = 3'd6;
  localparam logic [2:0] T_EQ  = 3'd7;

`ifdef ALU_EXEC_SEQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid, cmd_ready, cmd_imm_en;
  logic [2:0]     cmd_op, alu_op;
  logic [RAW-1:0] cmd_rd, cmd_rs1, cmd_rs2, dbg_addr;
  logic [W-1:0]   cmd_imm, alu_in_x, alu_in_y, alu_out_s, res_data, dbg_data;
  logic           alu_in_c, alu_out_c, alu_zero, alu_overflow;
  logic           res_valid, flag_c, flag_z, flag_v;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] mreg [NREG];

  always #5 clk = ~clk;

  alu_exec_seq #(.NREG(NREG), .RAW(RAW), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm), .alu_op(alu_op), .alu_in_c(alu_in_c),
    .alu_in_x(alu_in_x), .alu_in_y(alu_in_y), .alu_out_s(alu_out_s), .alu_out_c(alu_out_c),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .res_valid(res_valid),
    .res_data(res_data), .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Combinational ALU: subtract-style ops compute x + ~y + in_c.
  always_comb begin
    logic [4:0] add_sum, sub_sum;
    logic       add_v, sub_v;
    add_sum = {1'b0, alu_in_x} + {1'b0, alu_in_y} + {4'b0000, alu_in_c};
    sub_sum = {1'b0, alu_in_x} + {1'b0, ~alu_in_y} + {4'b0000, alu_in_c};
    add_v = (alu_in_x[3] == alu_in_y[3]) && (add_sum[3] != alu_in_x[3]);
    sub_v = (alu_in_x[3] != alu_in_y[3]) && (sub_sum[3] != alu_in_x[3]);
    alu_out_s = 4'h0;
    alu_out_c = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      T_ADD: begin alu_out_s = add_sum[3:0]; alu_out_c = add_sum[4]; alu_overflow = add_v; end
      T_SUB: begin alu_out_s = sub_sum[3:0]; alu_out_c = sub_sum[4]; alu_overflow = sub_v; end
      T_NOT: alu_out_s = ~alu_in_x;
      T_AND: alu_out_s = alu_in_x & alu_in_y;
      T_OR:  alu_out_s = alu_in_x | alu_in_y;
      T_XOR: alu_out_s = alu_in_x ^ alu_in_y;
      T_LT:  alu_out_s = {3'b000, sub_sum[3] ^ sub_v};
      T_EQ:  alu_out_s = {3'b000, (sub_sum[3:0] == 4'h0)};
      default: alu_out_s = 4'h0;
    endcase
    alu_zero = (alu_out_s == 4'h0);
  end

  // Expected result and flags from plain integer arithmetic.
  function automatic void ref_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                    output logic [3:0] r, output logic c, output logic z, output logic v);
    int ia, ib, sa, sb, t;
    ia = int'(a);
    ib = int'(b);
    sa = (ia > 7) ? ia - 16 : ia;
    sb = (ib > 7) ? ib - 16 : ib;
    c = 1'b0;
    v = 1'b0;
    case (op)
      T_ADD: begin t = ia + ib; c = (t > 15); v = ((sa + sb) > 7) || ((sa + sb) < -8); end
      T_SUB: begin t = ia - ib; c = (ia >= ib); v = ((sa - sb) > 7) || ((sa - sb) < -8); end
      T_NOT: t = 15 - ia;
      T_AND: t = ia & ib;
      T_OR:  t = ia | ib;
      T_XOR: t = ia ^ ib;
      T_LT:  t = (sa < sb) ? 1 : 0;
      T_EQ:  t = (ia == ib) ? 1 : 0;
      default: t = 0;
    endcase
    r = t[3:0];
    z = (r == 4'h0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 8) begin tick(); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout: cmd_ready=%b expected 1", name, cmd_ready);
    end
  endtask

  task automatic scramble_cmd();
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom);  cmd_rd = 2'($urandom); cmd_rs1 = 2'($urandom);
    cmd_rs2 = 2'($urandom); cmd_imm_en = 1'($urandom); cmd_imm = 4'($urandom);
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [RAW-1:0] rd, input logic [RAW-1:0] rs1,
                        input logic [RAW-1:0] rs2, input logic imm_en, input logic [W-1:0] imm, input int gap);
    logic [W-1:0] a, b, er;
    logic ec, ez, ev, nc;
    repeat (gap) tick();
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm_en = imm_en; cmd_imm = imm;
    cmd_valid = 1'b1;
    wait_ready("cmd");
    a = mreg[rs1];
    b = imm_en ? imm : mreg[rs2];
    nc = (op == T_SUB) || (op == T_LT) || (op == T_EQ);
    ref_model(op, a, b, er, ec, ez, ev);
    tick();
    scramble_cmd();
    checks++;
    if ({alu_op, alu_in_c, alu_in_x, alu_in_y, res_valid, cmd_ready} !== {op, nc, a, b, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL exec_drive op%0d: got op=%h c=%b x=%h y=%h rv=%b rdy=%b expected op=%h c=%b x=%h y=%h rv=0 rdy=0",
               op, alu_op, alu_in_c, alu_in_x, alu_in_y, res_valid, cmd_ready, op, nc, a, b);
    end
    tick();
    checks++;
    if ({res_valid, res_data, flag_c, flag_z, flag_v, cmd_ready} !== {1'b1, er, ec, ez, ev, BYP}) begin
      errors++;
      $display("FAIL writeback op%0d: got rv=%b data=%h czv=%b%b%b rdy=%b expected rv=1 data=%h czv=%b%b%b rdy=%b",
               op, res_valid, res_data, flag_c, flag_z, flag_v, cmd_ready, er, ec, ez, ev, BYP);
    end
    mreg[rd] = er;
    tick();
    dbg_addr = rd;
    #1;
    checks++;
    if ({res_valid, alu_op, alu_in_c, alu_in_x, alu_in_y, dbg_data} !== {1'b0, 3'b000, 1'b0, 8'h00, er}) begin
      errors++;
      $display("FAIL post_wb op%0d: got rv=%b op=%h c=%b x=%h y=%h dbg=%h expected rv=0 idle drive dbg=%h",
               op, res_valid, alu_op, alu_in_c, alu_in_x, alu_in_y, dbg_data, er);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({cmd_ready, res_valid, res_data, flag_c, flag_z, flag_v, alu_op, alu_in_c, alu_in_x, alu_in_y}
        !== {1'b1, 1'b0, 4'h0, 3'b000, 3'b000, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b data=%h op=%h x=%h y=%h expected rdy=1 rest 0",
               cmd_ready, res_valid, res_data, alu_op, alu_in_x, alu_in_y);
    end
    rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      mreg[i] = 4'h0;
      dbg_addr = 2'(i);
      #1;
      checks++;
      if (dbg_data !== 4'h0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h expected 0", i, dbg_data);
      end
    end
  endtask

  task automatic test_directed();
    do_cmd(T_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5, 0);
    dbg_addr = 2'd1;
    #1;
    checks++;
    if (dbg_data !== 4'd5) begin errors++; $display("FAIL load_r1: got %h expected 5", dbg_data); end
    do_cmd(T_SUB, 2'd2, 2'd1, 2'd0, 1'b1, 4'd7, 0);
    do_cmd(T_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 4'd7, 1);
    do_cmd(T_ADD, 2'd3, 2'd3, 2'd0, 1'b1, 4'd1, 0);
    do_cmd(T_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 4'd15, 2);
    do_cmd(T_ADD, 2'd3, 2'd3, 2'd0, 1'b1, 4'd1, 0);
    do_cmd(T_LT,  2'd2, 2'd1, 2'd0, 1'b1, 4'd7, 0);
    do_cmd(T_LT,  2'd2, 2'd1, 2'd0, 1'b1, 4'hE, 0);
    do_cmd(T_EQ,  2'd2, 2'd1, 2'd0, 1'b1, 4'd5, 0);
    do_cmd(T_EQ,  2'd2, 2'd1, 2'd0, 1'b1, 4'd4, 0);
    do_cmd(T_NOT, 2'd0, 2'd1, 2'd0, 1'b0, 4'd0, 0);
    do_cmd(T_AND, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0, 0);
    do_cmd(T_OR,  2'd2, 2'd2, 2'd0, 1'b0, 4'd0, 0);
    do_cmd(T_XOR, 2'd1, 2'd0, 2'd1, 1'b0, 4'd0, 0);
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      do_cmd(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 4'($urandom),
             int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    cmd_op = T_ADD; cmd_rd = 2'd1; cmd_rs1 = 2'd0; cmd_imm_en = 1'b1; cmd_imm = 4'd9;
    cmd_valid = 1'b1;
    wait_ready("rstmid");
    tick();
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, res_valid, res_data, alu_op, alu_in_c, alu_in_x, alu_in_y, flag_c, flag_z, flag_v}
        !== {1'b1, 1'b0, 4'h0, 3'b000, 1'b0, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset_mid_exec: got rdy=%b rv=%b data=%h op=%h x=%h y=%h expected rdy=1 rest 0",
               cmd_ready, res_valid, res_data, alu_op, alu_in_x, alu_in_y);
    end
    for (int i = 0; i < NREG; i++) mreg[i] = 4'h0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", cmd_ready); end
    repeat (3) begin
      if (res_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    dbg_addr = 2'd1;
    #1;
    checks++;
    if ({seen, dbg_data} !== {1'b0, 4'h0}) begin
      errors++;
      $display("FAIL dropped_cmd: got res_valid_seen=%b r1=%h expected 0 and 0", seen, dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e1, e2, e3;
    logic c, z, v;
    ref_model(T_ADD, mreg[0], 4'd3, e1, c, z, v);
    ref_model(T_ADD, e1, 4'd1, e2, c, z, v);
    ref_model(T_XOR, mreg[1], e2, e3, c, z, v);
    cmd_op = T_ADD; cmd_rd = 2'd2; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1; cmd_imm_en = 1'b1; cmd_imm = 4'd3;
    cmd_valid = 1'b1;
    wait_ready("b2b");
    tick();
    cmd_rd = 2'd3; cmd_rs1 = 2'd2; cmd_imm = 4'd1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_exec_ready: got %b expected 0", cmd_ready); end
    tick();
    checks++;
    if ({res_valid, res_data, cmd_ready} !== {1'b1, e1, BYP}) begin
      errors++;
      $display("FAIL b2b_wb1: got rv=%b data=%h rdy=%b expected 1 %h %b", res_valid, res_data, cmd_ready, e1, BYP);
    end
`ifdef ALU_EXEC_SEQ_BYPASS_EN
    tick();
    cmd_op = T_XOR; cmd_rd = 2'd0; cmd_rs1 = 2'd1; cmd_rs2 = 2'd3; cmd_imm_en = 1'b0;
    checks++;
    if ({alu_in_x, cmd_ready} !== {e1, 1'b0}) begin
      errors++;
      $display("FAIL fwd_rs1: got x=%h rdy=%b expected %h 0", alu_in_x, cmd_ready, e1);
    end
    tick();
    checks++;
    if ({res_valid, res_data, cmd_ready} !== {1'b1, e2, 1'b1}) begin
      errors++;
      $display("FAIL b2b_wb2_cycle4: got rv=%b data=%h rdy=%b expected 1 %h 1", res_valid, res_data, cmd_ready, e2);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (alu_in_y !== e2) begin errors++; $display("FAIL fwd_rs2: got y=%h expected %h", alu_in_y, e2); end
    tick();
    checks++;
    if ({res_valid, res_data} !== {1'b1, e3}) begin
      errors++;
      $display("FAIL b2b_wb3: got rv=%b data=%h expected 1 %h", res_valid, res_data, e3);
    end
    mreg[0] = e3;
`else
    tick();
    checks++;
    if ({cmd_ready, res_valid} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_idle: got rdy=%b rv=%b expected 1 0", cmd_ready, res_valid);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (alu_in_x !== e1) begin errors++; $display("FAIL b2b_x: got %h expected %h", alu_in_x, e1); end
    tick();
    checks++;
    if ({res_valid, res_data} !== {1'b1, e2}) begin
      errors++;
      $display("FAIL b2b_wb2: got rv=%b data=%h expected 1 %h", res_valid, res_data, e2);
    end
`endif
    mreg[2] = e1;
    mreg[3] = e2;
    tick();
    dbg_addr = 2'd3;
    #1;
    checks++;
    if (dbg_data !== e2) begin errors++; $display("FAIL b2b_r3: got %h expected %h", dbg_data, e2); end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_rd = 2'd0; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0;
    cmd_imm_en = 1'b0; cmd_imm = 4'd0; dbg_addr = 2'd0;
    test_reset();
    test_directed();
    test_random(30);
    test_reset_mid();
    test_back_to_back();
    test_random(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
Execution sequencer directly upstream of the 4-bit combinational ALU.
- Accepts register-level commands over a valid/ready handshake.
- Reads operands from an internal register file and drives the ALU operation and operand inputs.
- Captures the ALU result and flags, and writes the result back to the register file.
- Turns the stateless ALU into a small sequential datapath for the lab CPU.

Parameters:
- NREG, 4, number of architectural registers (power of 2, ≥2).
- RAW, 2, register address width, equal to log2(NREG).
- W, 4, data width; fixed at 4 to match the ALU, and elaboration errors otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when both valid and ready are high.
- cmd_op  in  3  ALU opcode: 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal.
- cmd_rd  in  RAW  destination register.
- cmd_rs1  in  RAW  source register for x.
- cmd_rs2  in  RAW  source register for y.
- cmd_imm_en  in  1  when 1, y comes from cmd_imm instead of rs2.
- cmd_imm  in  W  immediate operand.
- alu_op  out  3  to ALU op.
- alu_in_c  out  1  to ALU in_c.
- alu_in_x  out  W  to ALU in_x.
- alu_in_y  out  W  to ALU in_y.
- alu_out_s  in  W  from ALU out_s.
- alu_out_c  in  1  from ALU out_c.
- alu_zero  in  1  from ALU zero.
- alu_overflow  in  1  from ALU overflow.
- res_valid  out  1  one-cycle pulse when writeback occurs.
- res_data  out  W  value written back.
- flag_c  out  1  registered carry flag.
- flag_z  out  1  registered zero flag.
- flag_v  out  1  registered overflow flag.
- dbg_addr  in  RAW  debug read address.
- dbg_data  out  W  combinational read of register dbg_addr.

Behaviour:
- FSM states: IDLE → EXEC → WB → IDLE.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch op and rd, plus x=reg[rs1] and y=(cmd_imm_en ? cmd_imm : reg[rs2]).
  - Go to EXEC.
- EXEC:
  - cmd_ready=0.
  - Drive alu_op, alu_in_x and alu_in_y from the latches.
  - alu_in_c=1 for op 001/110/111 (two's-complement subtract) and 0 otherwise.
  - Capture alu_out_s, alu_out_c, alu_zero and alu_overflow into the result and flag registers at the clock edge.
  - Go to WB.
- WB:
  - reg[rd] ← captured result; res_valid=1; res_data=captured result.
  - flag_c/z/v reflect the captured flags from this cycle on.
  - Go to IDLE.
- ALU drive outside EXEC: alu_op=000, alu_in_c=0, x=y=0, so the ALU output is deterministic.
- Latency: res_valid is asserted exactly 2 cycles after the accepting edge. Throughput is 1 command per 3 cycles.
- Ops 110/111 write the zero-extended 1-bit result (0000 or 0001). Flags update for every op, including logic ops.
- Arithmetic wraps modulo 2^W. No saturation.
- rd==rs1 or rd==rs2 is legal: operands are latched at accept, so the old value is used.
- cmd_valid while cmd_ready=0 is ignored. Inputs may change freely; the upstream holds the command until accepted.
- Reset, asynchronous, at any time including mid-EXEC/WB:
  - state=IDLE; all registers, flags, res_valid and res_data go to 0; alu_* outputs go to the idle drive.
  - A command in flight is dropped with no writeback.
  - cmd_ready=1 in the first cycle after reset deasserts.
- dbg_data is purely combinational from the register array and reflects a WB write on the following cycle.

Optional Feature:
ALU_EXEC_SEQ_BYPASS_EN
- Defined:
  - cmd_ready=1 in both IDLE and WB. A handshake in WB goes directly to EXEC.
  - If the accepted rs1, or rs2 with cmd_imm_en=0, equals the rd being written that cycle, the operand is taken from the captured result (forwarded) instead of the stale register.
  - Throughput becomes 1 command per 2 cycles; latency is unchanged.
- Undefined: cmd_ready only in IDLE, with no forwarding logic.

Decomposition:
- Package alu_exec_pkg holds:
  - the opcode localparams (OP_ADD..OP_EQ);
  - the state enum (IDLE/EXEC/WB);
  - W=4;
  - function needs_cin(op), returning 1 for sub/lt/eq.
- Sub-module alu_exec_regfile: NREG×W storage with one synchronous write port (we, waddr, wdata), two combinational read ports and one debug port, all reset to 0.

Test Plan:
- Reset then load: ADD rd=1, rs1=0, imm_en, imm=5 → res_valid 2 cycles after accept; res_data=0101, reg1=5, flags c=0 z=0 v=0.
- SUB from r1=5 with imm=7 → res_data=1110, flag_c=0, flag_v=0, flag_z=0; alu_in_c=1 during EXEC.
- ADD r1=7 with imm=1 → res_data=1000, flag_v=1, flag_c=0. ADD 15+1 → 0000, flag_c=1, flag_z=1.
- Compare with r1=5: LT imm=7 → 0001; EQ imm=5 → 0001; EQ imm=4 → 0000. Check rd overwrite and dbg_data.
- Assert rst_n low during EXEC → no res_valid, reg[rd] unchanged (0 after reset), cmd_ready=1 one cycle after release.
- BYPASS_EN only: back-to-back ADD r2=r0+3, then ADD r3=r2+imm 1 accepted in WB → r3=0100, two commands complete in 4 cycles. Without the macro, cmd_ready stays 0 in WB.
